branch_redirect: RTL and testbench

- PC-generation and control-transfer stage downstream of the EX-stage branch comparator.
- Consumes the comparator's `should_branch`, together with jump decode and operands.
- Computes the control-transfer target, owns the architectural fetch PC register, and runs a flush FSM that kills wrong-path instructions in IF/ID.
- Raises a one-cycle instruction-address-misaligned trap that vectors to a fixed trap address.

---
 rtl/branch_redirect.sv | 129 ++++++++++++
 tb/tb_branch_redirect.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect.sv
`default_nettype none
// ============================================================================
//  Module   : branch_redirect
//  Purpose  : Fetch-PC owner and control-transfer redirect stage. Takes the
//             EX-stage branch/jump decision, forms the target, loads the PC,
//             runs the IF/ID flush sequence and traps on misaligned targets.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_redirect #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC      = 32'h0000_0100,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        should_branch,
   input  logic [31:0] ex_pc,
   input  logic [31:0] imm_out,
   input  logic [31:0] rs1,
   output logic [31:0] pc,
   output logic        flush,
   output logic        redirect,
   output logic        misalign_err,
   output logic [31:0] taken_count
);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES);

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_pc;
   logic        r_redirect;
   logic        r_misalign;
   logic [31:0] r_taken_count;

   state_t      w_state_nxt;
   logic [2:0]  w_cnt_nxt;
   logic [31:0] w_pc_nxt;
   logic        w_redirect_nxt;
   logic        w_misalign_nxt;
   logic [31:0] w_count_nxt;

   logic [31:0] w_jalr_sum;
   logic [31:0] w_target;
   logic        w_take;

   // JALR clears bit 0 of its sum; JAL and branches are PC-relative.
   // Only JALR changes the base, so jalr > {jal, branch} priority is enough.
   assign w_jalr_sum = rs1 + imm_out;
   assign w_target   = is_jalr ? {w_jalr_sum[31:1], 1'b0} : (ex_pc + imm_out);

   // In FLUSH the EX instruction is wrong-path, so it can never transfer.
   assign w_take = (r_state == ST_RUN) & ex_valid &
                   (is_jalr | is_jal | (is_branch & should_branch));

   // Next-state, next-PC and pulse generation for the RUN/FLUSH sequencer.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_pc_nxt       = r_pc;
      w_redirect_nxt = 1'b0;
      w_misalign_nxt = 1'b0;
      w_count_nxt    = r_taken_count;
      case (r_state)
         ST_RUN: begin
            if (w_take) begin
               w_state_nxt    = ST_FLUSH;
               w_cnt_nxt      = C_FLUSH_LOAD;
               w_redirect_nxt = 1'b1;
               if (w_target[1]) begin
                  w_pc_nxt       = TRAP_PC;
                  w_misalign_nxt = 1'b1;
               end else begin
                  w_pc_nxt    = w_target;
                  w_count_nxt = r_taken_count + 32'd1;
               end
            end else if (!stall) begin
               w_pc_nxt = r_pc + 32'd4;
            end
         end
         ST_FLUSH: begin
            if (!stall) begin
               w_pc_nxt  = r_pc + 32'd4;
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
      endcase
   end

   // State and architectural registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_cnt         <= 3'd0;
         r_pc          <= RESET_PC;
         r_redirect    <= 1'b0;
         r_misalign    <= 1'b0;
         r_taken_count <= 32'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_pc          <= w_pc_nxt;
         r_redirect    <= w_redirect_nxt;
         r_misalign    <= w_misalign_nxt;
         r_taken_count <= w_count_nxt;
      end
   end

   assign pc           = r_pc;
   assign flush        = (r_state == ST_FLUSH);
   assign redirect     = r_redirect;
   assign misalign_err = r_misalign;
   assign taken_count  = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_redirect
//  Purpose  : Randomised + directed bench for branch_redirect with a
//             queue-based scoreboard and a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect;

   localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] C_TRAP_PC  = 32'h0000_0100;
   localparam int          C_FLUSH    = 2;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        ex_valid;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic        should_branch;
   logic [31:0] ex_pc;
   logic [31:0] imm_out;
   logic [31:0] rs1;
   logic [31:0] pc;
   logic        flush;
   logic        redirect;
   logic        misalign_err;
   logic [31:0] taken_count;

   branch_redirect #(
      .RESET_PC     (C_RESET_PC),
      .TRAP_PC      (C_TRAP_PC),
      .FLUSH_CYCLES (C_FLUSH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .ex_valid      (ex_valid),
      .is_branch     (is_branch),
      .is_jal        (is_jal),
      .is_jalr       (is_jalr),
      .should_branch (should_branch),
      .ex_pc         (ex_pc),
      .imm_out       (imm_out),
      .rs1           (rs1),
      .pc            (pc),
      .flush         (flush),
      .redirect      (redirect),
      .misalign_err  (misalign_err),
      .taken_count   (taken_count)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        flush;
      logic        redirect;
      logic        misalign;
      logic [31:0] count;
   } exp_t;

   exp_t q_exp[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   pushed      = 0;

   // Reference model state: the fetch PC, how many flush cycles remain, and
   // the running count of successful transfers.
   logic [31:0] m_pc;
   int          m_left;
   logic [31:0] m_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model, queue the expected result.
   task automatic apply(input bit r, input bit st, input bit v, input bit br,
                        input bit jal, input bit jalr, input bit sb,
                        input logic [31:0] epc, input logic [31:0] im,
                        input logic [31:0] r1);
      exp_t        e;
      logic [31:0] tgt;
      bit          take;
      @(negedge clk);
      rst = r; stall = st; ex_valid = v; is_branch = br; is_jal = jal;
      is_jalr = jalr; should_branch = sb; ex_pc = epc; imm_out = im; rs1 = r1;
      e.redirect = 1'b0;
      e.misalign = 1'b0;
      if (r) begin
         m_pc = C_RESET_PC; m_left = 0; m_count = 32'd0;
      end else if (m_left > 0) begin
         if (!st) begin
            m_pc   = m_pc + 32'd4;
            m_left = m_left - 1;
         end
      end else begin
         take = v && (jalr || jal || (br && sb));
         if (jalr) tgt = (r1 + im) & 32'hFFFF_FFFE;
         else      tgt = epc + im;
         if (take) begin
            e.redirect = 1'b1;
            m_left     = C_FLUSH;
            if (tgt[1]) begin
               m_pc       = C_TRAP_PC;
               e.misalign = 1'b1;
            end else begin
               m_pc    = tgt;
               m_count = m_count + 32'd1;
            end
         end else if (!st) begin
            m_pc = m_pc + 32'd4;
         end
      end
      e.pc    = m_pc;
      e.flush = (m_left > 0);
      e.count = m_count;
      q_exp.push_back(e);
      pushed++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle the DUT presents a result, compare against the queue.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            vectors++;
            if (pc !== e.pc || flush !== e.flush || redirect !== e.redirect ||
                misalign_err !== e.misalign || taken_count !== e.count) begin
               miscompares++;
               $display("FAIL vec%0d: pc=%h/%h flush=%b/%b redirect=%b/%b misalign=%b/%b taken=%0d/%0d (actual/required)",
                        vectors, pc, e.pc, flush, e.flush, redirect, e.redirect,
                        misalign_err, e.misalign, taken_count, e.count);
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1; stall = 0; ex_valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
      should_branch = 0; ex_pc = 0; imm_out = 0; rs1 = 0;
      m_pc = C_RESET_PC; m_left = 0; m_count = 0;

      // Sequential fetch from reset
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);
      // Taken branch 0x40 + (-16) -> 0x30
      apply(0, 0, 1, 1, 0, 0, 1, 32'h40, 32'hFFFF_FFF0, 0);
      idle(3);
      // Not-taken branch
      apply(0, 0, 1, 1, 0, 0, 0, 32'h40, 32'hFFFF_FFF0, 0);
      idle(1);
      // JALR with bit 0 cleared
      apply(0, 0, 1, 0, 0, 1, 0, 0, 32'h4, 32'h1001);
      idle(3);
      // Misaligned JAL -> trap
      apply(0, 0, 1, 0, 1, 0, 0, 32'h100, 32'h6, 0);
      idle(3);
      // Stall held mid-FLUSH, then a wrong-path take inside FLUSH
      apply(0, 0, 1, 0, 1, 0, 0, 32'h200, 32'h8, 0);
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 1, 0, 1, 0, 0, 32'h300, 32'h40, 0);
      apply(0, 0, 1, 1, 0, 0, 1, 32'h300, 32'h40, 0);
      idle(2);
      // Take while stalled in RUN still redirects
      apply(0, 1, 1, 0, 1, 0, 0, 32'h400, 32'h10, 0);
      idle(3);
      // Reset during FLUSH
      apply(0, 0, 1, 0, 1, 0, 0, 32'h500, 32'h20, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // Multi-flag priority: jalr wins over jal/branch
      apply(0, 0, 1, 1, 1, 1, 1, 32'h800, 32'h10, 32'h2000);
      idle(3);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 5) == 0, 1'($urandom),
               $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFE, $urandom);
      end

      @(posedge clk);
      #2;
      if (q_exp.size() != 0 || vectors != pushed) begin
         miscompares++;
         $display("FAIL drain: checked=%0d queued=%0d", vectors, pushed);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
